// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU datapath constants, mode encodings and stage
//                payload helpers so every block derives CHUNK the same way.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Control bits that travel alongside each stage's operand payload.
    typedef struct packed {
        logic valid;
        logic carry;
        logic zero;
    } stage_flags_t;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_chunk_stage.sv
`default_nettype none
// ============================================================================
//  Module      : add_chunk_stage
//  Description : One pipeline slice: CHUNK-bit ripple of full-adder cells on
//                chunk IDX, followed by the registered stage payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_chunk_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic             carry_in,
    input  logic             zero_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] res_in,
    output logic             valid_out,
    output logic             carry_out,
    output logic             zero_out,
    output logic             ovf_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] res_out
);

    localparam int LSB = IDX * CHUNK;

    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_carry_msb;
    logic             w_chunk_zero;

    stage_flags_t     r_flags;
    logic             r_ovf;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;

    // Lower chunks arrive complete; only this stage's slice is overwritten.
    always_comb begin
        w_res       = res_in;
        w_carry     = carry_in;
        w_carry_msb = carry_in;
        for (int i = 0; i < CHUNK; i++) begin
            w_carry_msb = w_carry;
            {w_carry, w_res[LSB + i]} = full_add(a_in[LSB + i], b_in[LSB + i], w_carry);
        end
    end

    assign w_chunk_zero = ~|w_res[LSB +: CHUNK];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
            r_ovf   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else if (en) begin
            r_flags.valid <= valid_in;
            r_flags.carry <= w_carry;
            r_flags.zero  <= zero_in & w_chunk_zero;
            r_ovf         <= w_carry_msb ^ w_carry;
            r_a           <= a_in;
            r_b           <= b_in;
            r_res         <= w_res;
        end
    end

    assign valid_out = r_flags.valid;
    assign carry_out = r_flags.carry;
    assign zero_out  = r_flags.zero;
    assign ovf_out   = r_ovf;
    assign a_out     = r_a;
    assign b_out     = r_b;
    assign res_out   = r_res;

endmodule
`default_nettype wire

// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_add_sub
//  Description : STAGES-deep carry-chain adder/subtractor with valid/ready
//                handshaking; one chunk of the ripple resolved per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_W,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    // Index k is the input of stage k; index STAGES is the pipeline output.
    logic [STAGES:0]   w_valid;
    logic [STAGES:0]   w_carry;
    logic [STAGES:0]   w_zero;
    logic [STAGES-1:0] w_ovf;
    logic [WIDTH-1:0]  w_a   [0:STAGES];
    logic [WIDTH-1:0]  w_b   [0:STAGES];
    logic [WIDTH-1:0]  w_res [0:STAGES];
    logic              w_adv;
    logic              w_unused_tail;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_adv    = ~w_valid[STAGES] | out_ready;
    assign in_ready = w_adv;

    assign w_valid[0] = in_valid;
    assign w_carry[0] = sub;
    assign w_zero[0]  = 1'b1;
    assign w_a[0]     = a;
    assign w_b[0]     = (sub == SUB) ? ~b : b;
    assign w_res[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (w_adv),
            .valid_in  (w_valid[k]),
            .carry_in  (w_carry[k]),
            .zero_in   (w_zero[k]),
            .a_in      (w_a[k]),
            .b_in      (w_b[k]),
            .res_in    (w_res[k]),
            .valid_out (w_valid[k+1]),
            .carry_out (w_carry[k+1]),
            .zero_out  (w_zero[k+1]),
            .ovf_out   (w_ovf[k]),
            .a_out     (w_a[k+1]),
            .b_out     (w_b[k+1]),
            .res_out   (w_res[k+1])
        );
    end

    // Operands leaving the last stage and early-stage overflow bits have no consumer.
    assign w_unused_tail = ^{w_a[STAGES], w_b[STAGES], w_ovf};

    assign out_valid = w_valid[STAGES];
    assign result    = w_res[STAGES];
    assign cout      = w_carry[STAGES];
    assign overflow  = w_ovf[STAGES-1];
    assign zero      = w_zero[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_add_sub
//  Description : Directed self-checking bench for pipelined_add_sub, with
//                extra instances covering 8/1, 8/8 and 64/4 configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_add_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic        cout, overflow, zero;

    logic        s_in_valid, s_sub;
    logic [7:0]  s_a8, s_b8;
    logic [63:0] s_a64, s_b64;
    logic        ir81, v81, c81, o81, z81;
    logic        ir88, v88, c88, o88, z88;
    logic        ir64, v64, c64, o64, z64;
    logic [7:0]  r81, r88;
    logic [63:0] r64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .overflow(overflow), .zero(zero)
    );

    pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u8_1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(ir81),
        .a(s_a8), .b(s_b8), .sub(s_sub), .out_valid(v81), .out_ready(1'b1),
        .result(r81), .cout(c81), .overflow(o81), .zero(z81)
    );

    pipelined_add_sub #(.WIDTH(8), .STAGES(8)) u8_8 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(ir88),
        .a(s_a8), .b(s_b8), .sub(s_sub), .out_valid(v88), .out_ready(1'b1),
        .result(r88), .cout(c88), .overflow(o88), .zero(z88)
    );

    pipelined_add_sub #(.WIDTH(64), .STAGES(4)) u64_4 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(ir64),
        .a(s_a64), .b(s_b64), .sub(s_sub), .out_valid(v64), .out_ready(1'b1),
        .result(r64), .cout(c64), .overflow(o64), .zero(z64)
    );

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        s_in_valid = 1'b0; s_sub = 1'b0; s_a8 = '0; s_b8 = '0; s_a64 = '0; s_b64 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({out_valid, result, cout, overflow, zero, in_ready} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL reset_state got v=%b r=%h c=%b o=%b z=%b rdy=%b exp v=0 r=0 c=0 o=0 z=0 rdy=1",
                     out_valid, result, cout, overflow, zero, in_ready);
        end
        total++;
        if ({v81, v88, v64, ir81, ir88, ir64} !== 6'b000111) begin
            bad++;
            $display("FAIL reset_sweep got valids=%b%b%b readys=%b%b%b exp 000 111",
                     v81, v88, v64, ir81, ir88, ir64);
        end
    endtask

    // Issues one beat with out_ready=1 and checks latency 4 plus the flags.
    task automatic single_beat(input string name, input logic [31:0] ta, input logic [31:0] tb,
                               input logic ts, input logic [31:0] er, input logic ec,
                               input logic eo, input logic ez);
        int lat;
        logic [31:0] gr;
        logic gc, go, gz;
        lat = -1; gr = '0; gc = 1'b0; go = 1'b0; gz = 1'b0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = ta; b = tb; sub = ts;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (out_valid && lat < 0) begin
                lat = k; gr = result; gc = cout; go = overflow; gz = zero;
            end
        end
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL %s latency got=%0d exp=4", name, lat);
        end
        total++;
        if ({gr, gc, go, gz} !== {er, ec, eo, ez}) begin
            bad++;
            $display("FAIL %s value got r=%h c=%b o=%b z=%b exp r=%h c=%b o=%b z=%b",
                     name, gr, gc, go, gz, er, ec, eo, ez);
        end
    endtask

    task automatic test_add();
        single_beat("add_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_sub_overflow();
        logic [31:0] er [2];
        logic [2:0]  ef [2];
        int got;
        er[0] = 32'h7FFF_FFFF; ef[0] = 3'b110;
        er[1] = 32'hFFFF_FFFE; ef[1] = 3'b000;
        got = 0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = 32'h8000_0000; b = 32'd1; sub = 1'b1;
        @(negedge clk);
        a = 32'd5; b = 32'd7;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 2) in_valid = 1'b0;
            if (out_valid) begin
                if (got < 2) begin
                    total++;
                    if ({result, cout, overflow, zero} !== {er[got], ef[got]} || k !== got + 4) begin
                        bad++;
                        $display("FAIL sub_beat%0d got r=%h c=%b o=%b z=%b at %0d exp r=%h cov z=%b at %0d",
                                 got, result, cout, overflow, zero, k, er[got], ef[got], got + 4);
                    end
                end
                got++;
            end
        end
        total++;
        if (got !== 2) begin
            bad++;
            $display("FAIL sub_count got=%0d exp=2", got);
        end
    endtask

    task automatic test_back_to_back();
        int got;
        got = 0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = 32'd0; b = 32'd0; sub = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (result !== 32'(4 * got) || k !== got + 4) begin
                    bad++;
                    $display("FAIL b2b beat%0d got r=%h at cycle %0d exp r=%h at cycle %0d",
                             got, result, k, 32'(4 * got), got + 4);
                end
                got++;
            end
            if (k < 16) begin
                a = 32'(k); b = 32'(3 * k);
            end else begin
                in_valid = 1'b0;
            end
        end
        total++;
        if (got !== 16) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=16", got);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vs [8];
        logic [33:0] exp_q [$];
        logic [33:0] e;
        logic [32:0] wide;
        logic [35:0] prev;
        logic        stall_prev, acc_prev;
        int idx, got, k;
        va = '{32'd10, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678, 32'h8000_0000, 32'hDEAD_BEEF, 32'd7};
        vb = '{32'd3, 32'd10, 32'hFFFF_FFFF, 32'd1, 32'h1111_1111, 32'h8000_0000, 32'h0000_BEEF, 32'd7};
        vs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        idx = 0; got = 0; k = 0; stall_prev = 1'b0; acc_prev = 1'b0; prev = '0;
        while (got < 8 && k < 100) begin
            @(negedge clk);
            if (acc_prev) idx++;
            in_valid = (idx < 8);
            if (idx < 8) begin
                a = va[idx]; b = vb[idx]; sub = vs[idx];
            end
            out_ready = (k % 3 == 0);
            #1;
            total++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                bad++;
                $display("FAIL bp_in_ready cycle %0d got=%b exp=%b", k, in_ready, !(out_valid && !out_ready));
            end
            if (stall_prev) begin
                total++;
                if ({out_valid, result, cout, overflow, zero} !== prev) begin
                    bad++;
                    $display("FAIL bp_stable cycle %0d got=%h exp=%h", k,
                             {out_valid, result, cout, overflow, zero}, prev);
                end
            end
            acc_prev = in_valid && in_ready;
            if (acc_prev) begin
                wide = vs[idx] ? ({1'b0, va[idx]} + {1'b0, ~vb[idx]} + 33'd1)
                               : ({1'b0, va[idx]} + {1'b0, vb[idx]});
                exp_q.push_back({(wide[31:0] == 32'd0), wide[32], wide[31:0]});
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra beat got r=%h exp none", result);
                end else begin
                    e = exp_q.pop_front();
                    if ({zero, cout, result} !== e) begin
                        bad++;
                        $display("FAIL bp_beat%0d got z=%b c=%b r=%h exp z=%b c=%b r=%h",
                                 got, zero, cout, result, e[33], e[32], e[31:0]);
                    end
                end
                got++;
            end
            stall_prev = out_valid && !out_ready;
            prev = {out_valid, result, cout, overflow, zero};
            k++;
        end
        total++;
        if (got !== 8 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL bp_count got=%0d pending=%0d exp 8 and 0", got, exp_q.size());
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        int seen;
        seen = 0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 32'(100 + i); b = 32'd1;
            @(negedge clk);
        end
        in_valid = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({out_valid, result, cout, overflow, zero, in_ready} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL midreset_state got v=%b r=%h c=%b o=%b z=%b rdy=%b exp v=0 r=0 c=0 o=0 z=0 rdy=1",
                     out_valid, result, cout, overflow, zero, in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midreset_flush got %0d out_valid cycles exp 0", seen);
        end
    endtask

    // One beat into all three sweep instances; latency must equal each STAGES.
    task automatic sweep_beat(input string name, input logic [7:0] a8, input logic [7:0] b8,
                              input logic [63:0] a64, input logic [63:0] b64, input logic ts,
                              input logic [7:0] e8, input logic [2:0] f8,
                              input logic [63:0] e64, input logic [2:0] f64);
        int          lat  [3];
        int          elat [3];
        logic [63:0] gr   [3];
        logic [63:0] er   [3];
        logic [2:0]  gf   [3];
        logic [2:0]  ef   [3];
        elat = '{1, 8, 4};
        er = '{{56'd0, e8}, {56'd0, e8}, e64};
        ef = '{f8, f8, f64};
        lat = '{-1, -1, -1};
        gr = '{64'd0, 64'd0, 64'd0};
        gf = '{3'd0, 3'd0, 3'd0};
        @(negedge clk);
        s_in_valid = 1'b1; s_a8 = a8; s_b8 = b8; s_a64 = a64; s_b64 = b64; s_sub = ts;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) s_in_valid = 1'b0;
            if (v81 && lat[0] < 0) begin lat[0] = k; gr[0] = {56'd0, r81}; gf[0] = {c81, o81, z81}; end
            if (v88 && lat[1] < 0) begin lat[1] = k; gr[1] = {56'd0, r88}; gf[1] = {c88, o88, z88}; end
            if (v64 && lat[2] < 0) begin lat[2] = k; gr[2] = r64; gf[2] = {c64, o64, z64}; end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (lat[i] !== elat[i] || gr[i] !== er[i] || gf[i] !== ef[i]) begin
                bad++;
                $display("FAIL sweep_%s inst%0d got lat=%0d r=%h cov z=%b exp lat=%0d r=%h cov z=%b",
                         name, i, lat[i], gr[i], gf[i], elat[i], er[i], ef[i]);
            end
        end
    endtask

    task automatic test_param_sweep();
        sweep_beat("add_wrap", 8'hFF, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                   8'h00, 3'b101, 64'd0, 3'b101);
        sweep_beat("sub_ovf", 8'h80, 8'h01, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
                   8'h7F, 3'b110, 64'h7FFF_FFFF_FFFF_FFFF, 3'b110);
        sweep_beat("chunk_carry", 8'h0F, 8'h01, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                   8'h10, 3'b000, 64'h0001_0000_0000_0000, 3'b000);
        sweep_beat("sub_borrow", 8'h05, 8'h07, 64'd5, 64'd7, 1'b1,
                   8'hFE, 3'b000, 64'hFFFF_FFFF_FFFF_FFFE, 3'b000);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
